// File: rtl/store_unit_pkg.sv
// -----------------------------------------------------------------------------
// store_unit_pkg
// Shared types and helpers for the store path.
//   store_width_t  : access size requested by the store buffer
//   store_state_t  : store_controller FSM states
//   lane_t         : replicated write data plus byte-enable mask
//   lane_map()     : places a store's data onto the 32-bit bus lanes
//   is_misaligned(): true when the access crosses its natural alignment
// -----------------------------------------------------------------------------
package store_unit_pkg;

    typedef enum logic [1:0] {
        STORE_BYTE = 2'd0,
        STORE_HALF = 2'd1,
        STORE_WORD = 2'd2
    } store_width_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WRITE   = 2'd1,
        ST_RESPOND = 2'd2
    } store_state_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  byte_enable;
    } lane_t;

    localparam int unsigned TIMEOUT_WIDTH = 8;

    // Replicate the payload across all lanes so the memory can pick whichever
    // lanes the byte-enable selects; offset only shifts the enable mask.
    function automatic lane_t lane_map(
        input store_width_t width,
        input logic [1:0]   offset,
        input logic [31:0]  data
    );
        lane_t lanes;
        case (width)
            STORE_BYTE: begin
                lanes.data        = {4{data[7:0]}};
                lanes.byte_enable = 4'b0001 << offset;
            end
            STORE_HALF: begin
                lanes.data        = {2{data[15:0]}};
                lanes.byte_enable = 4'b0011 << offset;
            end
            default: begin
                lanes.data        = data;
                lanes.byte_enable = 4'b1111;
            end
        endcase
        return lanes;
    endfunction

    // Unused width encoding is treated as a word access.
    function automatic logic is_misaligned(
        input store_width_t width,
        input logic [1:0]   offset
    );
        logic bad;
        case (width)
            STORE_BYTE: bad = 1'b0;
            STORE_HALF: bad = offset[0];
            default:    bad = (offset != 2'b00);
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/store_interface.sv
// -----------------------------------------------------------------------------
// store_interface
// Pull-side handshake between the store buffer (master) and the store
// controller (slave).
//   request : single-cycle pulse, store fields valid in the same cycle
//   address : byte address of the store
//   data    : store payload, right-justified
//   width   : access size (store_width_t)
//   done    : one-cycle pulse when the store has been retired (any outcome)
// -----------------------------------------------------------------------------
interface store_interface;
    import store_unit_pkg::*;

    logic         request;
    logic [31:0]  address;
    logic [31:0]  data;
    store_width_t width;
    logic         done;

    modport master (
        output request, address, data, width,
        input  done
    );

    modport slave (
        input  request, address, data, width,
        output done
    );

endinterface

// File: rtl/store_controller.sv
// -----------------------------------------------------------------------------
// store_controller
// Takes one store at a time from the store buffer and performs it as a single
// 32-bit bus write with byte enables. Misaligned stores are rejected without
// touching the bus; bus errors and response timeouts abort the store. Every
// store, successful or not, is retired with a one-cycle done pulse.
//
// Parameters
//   TIMEOUT_CYCLES    : bus-wait cycles before a write aborts (1..255)
// Ports
//   clk_i             : clock, rising edge
//   rst_n_i           : asynchronous active-low reset
//   store_channel     : store buffer handshake (slave side)
//   bus_write_o       : write strobe, held until a response or timeout
//   bus_address_o     : word-aligned write address
//   bus_data_o        : lane-replicated write data
//   bus_byte_enable_o : active byte lanes
//   bus_ack_i         : write completed
//   bus_error_i       : write failed (wins over a simultaneous ack)
//   store_error_o     : one-cycle pulse alongside done when a store aborts
//   error_address_o   : byte address of the most recent aborted store
// -----------------------------------------------------------------------------
module store_controller
    import store_unit_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    store_interface.slave        store_channel,
    output logic                 bus_write_o,
    output logic [31:0]          bus_address_o,
    output logic [31:0]          bus_data_o,
    output logic [3:0]           bus_byte_enable_o,
    input  logic                 bus_ack_i,
    input  logic                 bus_error_i,
    output logic                 store_error_o,
    output logic [31:0]          error_address_o
);

    // Counter value in the last permitted wait cycle; reaching it without a
    // response aborts the write.
    localparam logic [TIMEOUT_WIDTH-1:0] TIMEOUT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

    store_state_t             state_q;
    logic [TIMEOUT_WIDTH-1:0] timeout_count_q;
    logic [31:0]              addr_q;
    logic                     done_q;
    lane_t                    lane_next;
    logic                     request_misaligned;

    // NOTE: each signal here is a single unconditional assignment, so every
    // path is covered and no latch can be inferred.
    always_comb begin
        lane_next          = lane_map(store_channel.width, store_channel.address[1:0],
                                      store_channel.data);
        request_misaligned = is_misaligned(store_channel.width, store_channel.address[1:0]);
    end

    assign store_channel.done = done_q;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the values from before this clock edge.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            // NOTE: the bus data/address registers are reset too, so a store
            // cut short by reset leaves nothing stale on the bus.
            state_q           <= ST_IDLE;
            timeout_count_q   <= '0;
            addr_q            <= '0;
            done_q            <= 1'b0;
            store_error_o     <= 1'b0;
            error_address_o   <= '0;
            bus_write_o       <= 1'b0;
            bus_address_o     <= '0;
            bus_data_o        <= '0;
            bus_byte_enable_o <= '0;
        end else begin
            // done and store_error_o are pulses: only the entry into RESPOND
            // raises them for the single RESPOND cycle.
            done_q        <= 1'b0;
            store_error_o <= 1'b0;

            case (state_q)
                ST_IDLE: begin
                    if (store_channel.request) begin
                        addr_q <= store_channel.address;
                        if (request_misaligned) begin
                            // Rejected before any bus activity.
                            state_q         <= ST_RESPOND;
                            done_q          <= 1'b1;
                            store_error_o   <= 1'b1;
                            error_address_o <= store_channel.address;
                        end else begin
                            state_q           <= ST_WRITE;
                            timeout_count_q   <= '0;
                            bus_write_o       <= 1'b1;
                            bus_address_o     <= {store_channel.address[31:2], 2'b00};
                            bus_data_o        <= lane_next.data;
                            bus_byte_enable_o <= lane_next.byte_enable;
                        end
                    end
                end

                ST_WRITE: begin
                    if (bus_ack_i || bus_error_i) begin
                        state_q     <= ST_RESPOND;
                        bus_write_o <= 1'b0;
                        done_q      <= 1'b1;
                        // An error alongside an ack still counts as a failure.
                        if (bus_error_i) begin
                            store_error_o   <= 1'b1;
                            error_address_o <= addr_q;
                        end
                    end else if (timeout_count_q == TIMEOUT_LAST) begin
                        state_q         <= ST_RESPOND;
                        bus_write_o     <= 1'b0;
                        done_q          <= 1'b1;
                        store_error_o   <= 1'b1;
                        error_address_o <= addr_q;
                    end else begin
                        timeout_count_q <= timeout_count_q + 1'b1;
                    end
                end

                ST_RESPOND: begin
                    state_q <= ST_IDLE;
                end

                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_controller.sv
// -----------------------------------------------------------------------------
// tb_store_controller
// Self-checking bench for store_controller (TIMEOUT_CYCLES = 4). The bench
// plays the store buffer and the memory; expected outcomes are queued when a
// store is issued and popped when done is observed.
// -----------------------------------------------------------------------------
module tb_store_controller;
    import store_unit_pkg::*;

    localparam int unsigned TIMEOUT = 4;

    logic        clk_i   = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        bus_write_o;
    logic [31:0] bus_address_o;
    logic [31:0] bus_data_o;
    logic [3:0]  bus_byte_enable_o;
    logic        bus_ack_i   = 1'b0;
    logic        bus_error_i = 1'b0;
    logic        store_error_o;
    logic [31:0] error_address_o;

    store_interface store_if();

    store_controller #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
        .clk_i             (clk_i),
        .rst_n_i           (rst_n_i),
        .store_channel     (store_if),
        .bus_write_o       (bus_write_o),
        .bus_address_o     (bus_address_o),
        .bus_data_o        (bus_data_o),
        .bus_byte_enable_o (bus_byte_enable_o),
        .bus_ack_i         (bus_ack_i),
        .bus_error_i       (bus_error_i),
        .store_error_o     (store_error_o),
        .error_address_o   (error_address_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  be;
        bit          err;
        logic [31:0] err_addr;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int unsigned cycle  = 0;
    int unsigned req_cycle = 0;

    // Bus/handshake monitor, sampled 1 time unit after each rising edge.
    int          write_cycles  = 0;
    int          unstable_count = 0;
    int          done_count    = 0;
    logic        prev_write    = 1'b0;
    logic [31:0] prev_addr     = '0;
    logic [31:0] prev_data     = '0;
    logic [3:0]  prev_be       = '0;

    always @(posedge clk_i) cycle <= cycle + 1;

    always begin
        @(posedge clk_i);
        #1;
        if (bus_write_o) begin
            write_cycles = write_cycles + 1;
            if (prev_write && (bus_address_o !== prev_addr || bus_data_o !== prev_data ||
                               bus_byte_enable_o !== prev_be))
                unstable_count = unstable_count + 1;
        end
        if (store_if.done) done_count = done_count + 1;
        prev_write = bus_write_o;
        prev_addr  = bus_address_o;
        prev_data  = bus_data_o;
        prev_be    = bus_byte_enable_o;
    end

    // Reference lane model: byte i of the bus carries payload byte (i mod size),
    // and lanes offset..offset+size-1 are enabled.
    function automatic exp_t model(input store_width_t w, input logic [31:0] a,
                                   input logic [31:0] d);
        exp_t e;
        int   sz;
        int   off;
        sz  = (w == STORE_BYTE) ? 1 : (w == STORE_HALF) ? 2 : 4;
        off = int'(a[1:0]);
        e.err      = (off % sz) != 0;
        e.addr     = a & 32'hFFFF_FFFC;
        e.err_addr = a;
        e.data     = '0;
        e.be       = '0;
        for (int i = 0; i < 4; i++) begin
            e.data[8*i +: 8] = d[8*(i % sz) +: 8];
            if (i >= off && i < off + sz) e.be[i] = 1'b1;
        end
        return e;
    endfunction

    // Drives a request pulse and queues its expected result. Returns at the
    // falling edge in the cycle after the request (first WRITE cycle).
    task automatic issue(input store_width_t w, input logic [31:0] a, input logic [31:0] d);
        @(negedge clk_i);
        store_if.request = 1'b1;
        store_if.width   = w;
        store_if.address = a;
        store_if.data    = d;
        req_cycle        = cycle;
        exp_q.push_back(model(w, a, d));
        @(negedge clk_i);
        store_if.request = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk_i);
            if (store_if.done) seen = 1'b1;
        end
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        @(negedge clk_i);
        checks++; if (bus_write_o !== 1'b0) begin errors++; $display("FAIL reset_write: got %b expected 0", bus_write_o); end
        checks++; if (bus_address_o !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", bus_address_o); end
        checks++; if (bus_data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", bus_data_o); end
        checks++; if (bus_byte_enable_o !== 4'h0) begin errors++; $display("FAIL reset_be: got %b expected 0", bus_byte_enable_o); end
        checks++; if (store_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", store_if.done); end
        checks++; if (store_error_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", store_error_o); end
        checks++; if (error_address_o !== 32'h0) begin errors++; $display("FAIL reset_err_addr: got %h expected 0", error_address_o); end
        rst_n_i = 1'b1;
    endtask

    task automatic test_byte_store();
        exp_t e;
        int   w0;
        w0 = write_cycles;
        issue(STORE_BYTE, 32'h0000_1003, 32'hFFFF_FFAB);
        checks++; if (bus_write_o !== 1'b1) begin errors++; $display("FAIL byte_first_write: got %b expected 1", bus_write_o); end
        checks++; if (bus_address_o !== 32'h0000_1000) begin errors++; $display("FAIL byte_addr: got %h expected 00001000", bus_address_o); end
        checks++; if (bus_data_o !== 32'hABAB_ABAB) begin errors++; $display("FAIL byte_data: got %h expected abababab", bus_data_o); end
        checks++; if (bus_byte_enable_o !== 4'b1000) begin errors++; $display("FAIL byte_be: got %b expected 1000", bus_byte_enable_o); end
        @(negedge clk_i);
        @(negedge clk_i);
        bus_ack_i = 1'b1;
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        checks++; if (store_if.done !== 1'b1) begin errors++; $display("FAIL byte_done: got %b expected 1", store_if.done); end
        checks++; if (bus_write_o !== 1'b0) begin errors++; $display("FAIL byte_write_drop: got %b expected 0", bus_write_o); end
        checks++; if (cycle - req_cycle !== 4) begin errors++; $display("FAIL byte_latency: got %0d expected 4", cycle - req_cycle); end
        checks++; if (write_cycles - w0 !== 3) begin errors++; $display("FAIL byte_write_cycles: got %0d expected 3", write_cycles - w0); end
        checks++; if (unstable_count !== 0) begin errors++; $display("FAIL byte_stable: got %0d changes expected 0", unstable_count); end
        e = exp_q.pop_front();
        checks++; if (store_error_o !== e.err) begin errors++; $display("FAIL byte_error: got %b expected %b", store_error_o, e.err); end
        @(negedge clk_i);
        checks++; if (store_if.done !== 1'b0) begin errors++; $display("FAIL byte_done_pulse: got %b expected 0", store_if.done); end
    endtask

    task automatic test_half_store();
        exp_t e;
        issue(STORE_HALF, 32'h0000_2002, 32'hABCD_1234);
        bus_ack_i = 1'b1;
        checks++; if (bus_data_o !== 32'h1234_1234) begin errors++; $display("FAIL half_data: got %h expected 12341234", bus_data_o); end
        checks++; if (bus_byte_enable_o !== 4'b1100) begin errors++; $display("FAIL half_be: got %b expected 1100", bus_byte_enable_o); end
        checks++; if (bus_address_o !== 32'h0000_2000) begin errors++; $display("FAIL half_addr: got %h expected 00002000", bus_address_o); end
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        checks++; if (store_if.done !== 1'b1) begin errors++; $display("FAIL half_done: got %b expected 1", store_if.done); end
        checks++; if (cycle - req_cycle !== 2) begin errors++; $display("FAIL half_latency: got %0d expected 2", cycle - req_cycle); end
        e = exp_q.pop_front();
        checks++; if (store_error_o !== e.err) begin errors++; $display("FAIL half_error: got %b expected %b", store_error_o, e.err); end
    endtask

    task automatic test_misaligned();
        exp_t e;
        int   w0;
        w0 = write_cycles;
        issue(STORE_WORD, 32'h0000_3001, 32'h5555_AAAA);
        checks++; if (store_if.done !== 1'b1) begin errors++; $display("FAIL misal_done: got %b expected 1", store_if.done); end
        checks++; if (store_error_o !== 1'b1) begin errors++; $display("FAIL misal_err: got %b expected 1", store_error_o); end
        checks++; if (error_address_o !== 32'h0000_3001) begin errors++; $display("FAIL misal_err_addr: got %h expected 00003001", error_address_o); end
        e = exp_q.pop_front();
        checks++; if (store_error_o !== e.err) begin errors++; $display("FAIL misal_model: got %b expected %b", store_error_o, e.err); end
        @(negedge clk_i);
        checks++; if (store_if.done !== 1'b0 || store_error_o !== 1'b0) begin errors++; $display("FAIL misal_pulse: got done=%b err=%b expected 0/0", store_if.done, store_error_o); end
        checks++; if (write_cycles - w0 !== 0) begin errors++; $display("FAIL misal_no_bus: got %0d write cycles expected 0", write_cycles - w0); end
        checks++; if (error_address_o !== 32'h0000_3001) begin errors++; $display("FAIL misal_err_hold: got %h expected 00003001", error_address_o); end
        issue(STORE_HALF, 32'h0000_4003, 32'h0000_BEEF);
        checks++; if (store_error_o !== 1'b1 || bus_write_o !== 1'b0) begin errors++; $display("FAIL misal_half: got err=%b write=%b expected 1/0", store_error_o, bus_write_o); end
        e = exp_q.pop_front();
        @(negedge clk_i);
    endtask

    task automatic test_bus_error();
        exp_t e;
        issue(STORE_WORD, 32'h0000_6000, 32'h1122_3344);
        bus_ack_i   = 1'b1;
        bus_error_i = 1'b1;
        checks++; if (bus_data_o !== 32'h1122_3344 || bus_byte_enable_o !== 4'b1111) begin errors++; $display("FAIL berr_lanes: got %h/%b expected 11223344/1111", bus_data_o, bus_byte_enable_o); end
        @(negedge clk_i);
        bus_ack_i   = 1'b0;
        bus_error_i = 1'b0;
        checks++; if (store_if.done !== 1'b1 || store_error_o !== 1'b1) begin errors++; $display("FAIL berr_pulse: got done=%b err=%b expected 1/1", store_if.done, store_error_o); end
        checks++; if (error_address_o !== 32'h0000_6000) begin errors++; $display("FAIL berr_addr: got %h expected 00006000", error_address_o); end
        e = exp_q.pop_front();
        @(negedge clk_i);
    endtask

    task automatic test_timeout();
        exp_t e;
        bit   seen;
        int   w0;
        int   d0;
        w0 = write_cycles;
        issue(STORE_WORD, 32'h0000_5000, 32'hDEAD_BEEF);
        // A request while the write is pending must be ignored.
        @(negedge clk_i);
        store_if.request = 1'b1;
        store_if.address = 32'h0000_9990;
        @(negedge clk_i);
        store_if.request = 1'b0;
        wait_done(10, seen);
        checks++; if (seen !== 1'b1) begin errors++; $display("FAIL tmo_done: got no done expected done within 10 cycles"); end
        checks++; if (cycle - req_cycle !== 5) begin errors++; $display("FAIL tmo_latency: got %0d expected 5", cycle - req_cycle); end
        checks++; if (write_cycles - w0 !== 4) begin errors++; $display("FAIL tmo_write_cycles: got %0d expected 4", write_cycles - w0); end
        checks++; if (store_error_o !== 1'b1) begin errors++; $display("FAIL tmo_err: got %b expected 1", store_error_o); end
        checks++; if (error_address_o !== 32'h0000_5000) begin errors++; $display("FAIL tmo_err_addr: got %h expected 00005000", error_address_o); end
        e  = exp_q.pop_front();
        d0 = done_count;
        repeat (5) @(negedge clk_i);
        checks++; if (done_count - d0 !== 0 || bus_write_o !== 1'b0) begin errors++; $display("FAIL tmo_ignored_req: got %0d extra done, write=%b expected 0/0", done_count - d0, bus_write_o); end
    endtask

    task automatic test_reset_mid_write();
        exp_t e;
        int   d0;
        issue(STORE_WORD, 32'h0000_7000, 32'h0BAD_F00D);
        @(negedge clk_i);
        d0 = done_count;
        rst_n_i = 1'b0;
        #1;
        checks++; if (bus_write_o !== 1'b0) begin errors++; $display("FAIL rstmid_write: got %b expected 0", bus_write_o); end
        checks++; if (error_address_o !== 32'h0) begin errors++; $display("FAIL rstmid_err_addr: got %h expected 0", error_address_o); end
        e = exp_q.pop_back();
        @(negedge clk_i);
        rst_n_i = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++; if (done_count - d0 !== 0 || store_error_o !== 1'b0) begin errors++; $display("FAIL rstmid_no_done: got %0d done err=%b expected 0/0", done_count - d0, store_error_o); end
        issue(STORE_WORD, 32'h0000_8000, 32'hCAFE_F00D);
        bus_ack_i = 1'b1;
        checks++; if (bus_address_o !== 32'h0000_8000 || bus_data_o !== 32'hCAFE_F00D) begin errors++; $display("FAIL rstmid_next: got %h/%h expected 00008000/cafef00d", bus_address_o, bus_data_o); end
        @(negedge clk_i);
        bus_ack_i = 1'b0;
        checks++; if (store_if.done !== 1'b1 || store_error_o !== 1'b0) begin errors++; $display("FAIL rstmid_next_done: got done=%b err=%b expected 1/0", store_if.done, store_error_o); end
        e = exp_q.pop_front();
    endtask

    task automatic test_back_to_back();
        exp_t         e;
        store_width_t w;
        logic [31:0]  a;
        int unsigned  prev_done;
        int           completed;
        int           w0;
        completed = 0;
        prev_done = 0;
        @(negedge clk_i);
        bus_ack_i = 1'b1;
        for (int n = 0; n < 10; n++) begin
            w = store_width_t'($urandom_range(0, 2));
            a = $urandom;
            if (w == STORE_HALF) a[0] = 1'b0;
            if (w == STORE_WORD) a[1:0] = 2'b00;
            w0 = write_cycles;
            issue(w, a, $urandom);
            if (exp_q.size() == 0) begin
                checks++; errors++; $display("FAIL b2b_queue: got empty expected 1 entry");
            end else begin
                e = exp_q[0];
                checks++; if (bus_address_o !== e.addr || bus_data_o !== e.data || bus_byte_enable_o !== e.be) begin
                    errors++; $display("FAIL b2b_lanes[%0d]: got %h/%h/%b expected %h/%h/%b", n, bus_address_o, bus_data_o, bus_byte_enable_o, e.addr, e.data, e.be);
                end
            end
            @(negedge clk_i);
            checks++; if (store_if.done !== 1'b1) begin errors++; $display("FAIL b2b_done[%0d]: got %b expected 1", n, store_if.done); end
            checks++; if (write_cycles - w0 !== 1) begin errors++; $display("FAIL b2b_write[%0d]: got %0d expected 1", n, write_cycles - w0); end
            if (n > 0) begin
                checks++; if (cycle - prev_done !== 3) begin errors++; $display("FAIL b2b_period[%0d]: got %0d expected 3", n, cycle - prev_done); end
            end
            prev_done = cycle;
            if (store_if.done === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                completed++;
            end
        end
        bus_ack_i = 1'b0;
        checks++; if (completed !== 10 || exp_q.size() !== 0) begin errors++; $display("FAIL b2b_count: got %0d completed, %0d pending expected 10/0", completed, exp_q.size()); end
    endtask

    initial begin
        store_if.request = 1'b0;
        store_if.address = '0;
        store_if.data    = '0;
        store_if.width   = STORE_BYTE;
        test_reset();
        test_byte_store();
        test_half_store();
        test_misaligned();
        test_bus_error();
        test_timeout();
        test_reset_mid_write();
        test_back_to_back();
        repeat (2) @(negedge clk_i);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish within 100000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/store_controller.md
STORE_CONTROLLER -- requirements
Module: store_controller

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max bus-wait cycles before a transaction aborts (range 1..255).
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port store_channel  store_interface.slave  --  store buffer pull side; request/address[31:0]/data[31:0]/width (store_width_t) inputs, done output.
REQ-005 SHALL have port bus_write_o  output  1  memory write strobe, held until a response arrives.
REQ-006 SHALL have port bus_address_o  output  32  word-aligned write address (bits [1:0] = 0).
REQ-007 SHALL have port bus_data_o  output  32  lane-replicated write data.
REQ-008 SHALL have port bus_byte_enable_o  output  4  active byte lanes.
REQ-009 SHALL have port bus_ack_i  input  1  memory write completed.
REQ-010 SHALL have port bus_error_i  input  1  memory write failed.
REQ-011 SHALL have port store_error_o  output  1  one-cycle pulse: store aborted (misaligned, bus error, or timeout).
REQ-012 SHALL have port error_address_o  output  32  full byte address of the last aborted store; held until the next abort.

Function
REQ-013 SHALL implement FSM IDLE, WRITE, RESPOND.
REQ-014 IDLE: on request=1, SHALL latch address/data/width; a misaligned store goes to RESPOND with error flagged, otherwise to WRITE.
REQ-015 Misaligned: HALF with address[0]=1, or WORD with address[1:0]!=0; no bus transaction SHALL be issued.
REQ-016 request is a single-cycle pulse; it SHALL be captured in IDLE only and ignored in every other state.
REQ-017 WRITE: bus_write_o=1 with stable address/data/byte-enable; the FSM SHALL stay in WRITE until bus_ack_i, bus_error_i, or timeout, then go to RESPOND.
REQ-018 First bus_write_o cycle SHALL be the cycle after the request cycle; bus_write_o SHALL drop in the cycle after the response.
REQ-019 bus_ack_i and bus_error_i both high in the same cycle SHALL be treated as an error.
REQ-020 Timeout: an 8-bit counter clears on entry to WRITE and increments each WRITE cycle with no response; on reaching TIMEOUT_CYCLES it SHALL abort as an error.
REQ-021 RESPOND: done=1 for exactly one cycle on every outcome so the buffer always advances; store_error_o pulses in the same cycle on error; the FSM SHALL then return to IDLE.
REQ-022 Lane mapping (o = address[1:0]):
  - BYTE: data = {4{data[7:0]}}, byte enable = 0001<<o
  - HALF: data = {2{data[15:0]}}, byte enable = 0011<<o
  - WORD: data = data, byte enable = 1111
REQ-023 Throughput: at most one store per 3 cycles (IDLE->WRITE->RESPOND); with an ack in the first WRITE cycle, done is asserted 2 cycles after request.
REQ-024 Outputs other than done/store_error_o/error_address_o SHALL be registered, with no combinational path from bus inputs.

Reset
REQ-025 On rst_n_i=0, at any time including mid-transaction, SHALL force FSM=IDLE, bus_write_o=0, done=0, store_error_o=0, timeout counter=0, error_address_o=0, bus_address_o/bus_data_o/bus_byte_enable_o=0.
REQ-026 A transaction interrupted by reset SHALL be dropped, with no done and no error.

Structure
REQ-027 store_width_t and the FSM state enum SHALL live in store_unit_pkg; the lane mapping SHALL be a package function.
REQ-028 Single module, no sub-modules.

Verification
REQ-029 BYTE store, address 0x1003, data 0xAB, ack 2 cycles after bus_write_o -> bus_address_o=0x1000, bus_data_o=0xABABABAB, byte enable=1000, done one pulse the cycle after ack.
REQ-030 HALF store, address 0x2002, data 0x1234, immediate ack -> bus_data_o=0x12341234, byte enable=1100, done 2 cycles after request.
REQ-031 WORD store to 0x3001 -> bus_write_o never rises; done and store_error_o pulse together; error_address_o=0x3001.
REQ-032 WORD store, no response, TIMEOUT_CYCLES=4 -> bus_write_o high 4 cycles then drops; done + store_error_o pulse.
REQ-033 rst_n_i low mid-WRITE -> bus_write_o=0 immediately (asynchronously), no done; next request is handled normally.
REQ-034 Back-to-back buffer requests with bus_ack_i tied high -> each store completes in 3 cycles, outputs match the lane mapping, and no request is lost.
